fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC owner, single-outstanding imem requester, one-entry output buffer.
// Optional FETCH_PERF_EN adds saturating fetched/killed response counters.
module fetch_unit #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            takebranch,
  input  logic [XLEN-1:0] jal_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready,
  output logic            flush_ifid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_killed
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic            buf_free;
  logic            accept;
  logic [XLEN-1:0] target;

  assign buf_free       = !out_valid_q || out_ready;
  assign imem_req_valid = (state_q == S_REQ) && buf_free && !takebranch && !reset;
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_q;
  assign flush_ifid     = takebranch && !reset;
  assign target         = jal_addr & ~XLEN'(3);

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (takebranch) begin
      // The request is withdrawn in a redirect cycle, so REQ never hands off a
      // stale request here; only an already-issued one can need killing.
      pc_d        = target;
      out_valid_d = 1'b0;
      case (state_q)
        S_WAIT, S_KILL: state_d = imem_resp_valid ? S_REQ : S_KILL;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_instr_d = imem_resp_data;
            state_d     = S_REQ;
          end
        end
        S_KILL: begin
          if (imem_resp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_killed_q;
  logic        fetched_now, killed_now;

  assign fetched_now = (state_q == S_WAIT) && imem_resp_valid && !takebranch;
  assign killed_now  = imem_resp_valid &&
                       ((state_q == S_KILL) || ((state_q == S_WAIT) && takebranch));

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      if (fetched_now && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (killed_now  && (perf_killed_q  != '1)) perf_killed_q  <= perf_killed_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a
// transaction-level model (pending-request record with a stale flag, one-entry buffer).
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, takebranch, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        out_valid, out_ready, flush_ifid;
  logic [31:0] jal_addr, imem_req_addr, imem_resp_data, out_pc, out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_killed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .takebranch(takebranch), .jal_addr(jal_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .flush_ifid(flush_ifid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
  );

  int unsigned n_assert = 0, n_fail = 0;

  // Reference model
  logic        m_pend = 1'b0, m_stale = 1'b0, m_bv = 1'b0;
  logic [31:0] m_pc = RPC, m_req_pc = '0, m_bpc = '0, m_binstr = '0;
  logic [31:0] m_fetched = '0, m_killed = '0;

  // Memory responder state
  logic        mem_busy = 1'b0;
  int unsigned mem_cnt = 0, mem_lat = 1;
  logic [31:0] mem_addr = '0;
  logic        saw_zero_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model and memory.
  task automatic cycle(input logic rst, input logic br, input logic [31:0] tgt,
                       input logic ordy, input logic rdy);
    logic        resp_now, e_rv, acc_dut;
    logic [31:0] dut_addr;
    reset      = rst;
    takebranch = br;
    jal_addr   = tgt;
    out_ready  = ordy;
    resp_now   = mem_busy && (mem_cnt == 0);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? mem_word(mem_addr) : $urandom;
    imem_req_ready  = rdy && !mem_busy;
    #2;
    e_rv = !rst && !m_pend && (!m_bv || ordy) && !br;
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    if (e_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("flush_ifid", 32'(flush_ifid), 32'(br && !rst));
    chk("out_valid", 32'(out_valid), 32'(m_bv));
    if (m_bv) begin
      chk("out_pc", out_pc, m_bpc);
      chk("out_instr", out_instr, m_binstr);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_killed", perf_killed, m_killed);
`endif
    acc_dut  = imem_req_valid && imem_req_ready;
    dut_addr = imem_req_addr;

    if (rst) begin
      m_pc = RPC; m_pend = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
      m_bpc = '0; m_binstr = '0; m_fetched = '0; m_killed = '0;
    end else begin
      if (m_bv && ordy) m_bv = 1'b0;
      if (resp_now && m_pend) begin
        if (br || m_stale) m_killed = sat_inc(m_killed);
        else begin
          m_bv = 1'b1; m_bpc = m_req_pc; m_binstr = mem_word(m_req_pc);
          m_fetched = sat_inc(m_fetched);
        end
        m_pend = 1'b0;
      end
      if (br) begin
        m_pc = tgt & ~32'h3;
        m_bv = 1'b0;
        if (m_pend) m_stale = 1'b1;
      end else if (e_rv && imem_req_ready) begin
        m_pend = 1'b1; m_stale = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    if (resp_now) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc_dut) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat - 1;
      mem_addr = dut_addr;
      if (dut_addr == 32'h0) saw_zero_req = 1'b1;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic wait_pend(input string tag);
    for (int unsigned i = 0; i < 10 && !m_pend; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk(tag, 32'(m_pend), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int unsigned i = 0; i < 10 && m_pend; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk(tag, 32'(m_pend), 32'd0);
  endtask

  initial begin
    logic [31:0] held_pc, held_instr;
    reset = 1'b1; takebranch = 1'b0; jal_addr = '0; out_ready = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset cycle with a redirect asserted: reset wins, no flush.
    cycle(1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);

    // Streaming with 1-cycle memory: 0x100, 0x104, 0x108...
    mem_lat = 1;
    run(12);

    // Backpressure with a full buffer.
    for (int unsigned i = 0; i < 4 && !m_bv; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    held_pc = out_pc; held_instr = out_instr;
    for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_pc_stable", out_pc, held_pc);
    chk("stall_instr_stable", out_instr, held_instr);
    run(6);

    // Redirect while waiting on a 2-cycle response.
    mem_lat = 2;
    wait_pend("wait_pend_br");
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
    run(8);

    // Redirect to 0x110, then redirect to 0x400 in the cycle 0x110 would issue.
    mem_lat = 1;
    wait_idle("idle_br2");
    cycle(1'b0, 1'b1, 32'h0000_0110, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    run(8);

    // PC wrap at the top of the address space.
    wait_idle("idle_wrap");
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run(8);
    chk("wrap_to_zero", 32'(saw_zero_req), 32'd1);

    // Reset while a request is outstanding; its late response must be ignored.
    mem_lat = 2;
    wait_pend("wait_pend_rst");
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    run(8);

    // Random traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      mem_lat = $urandom_range(1, 3);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
